// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM with combinational reads between the fetch port and
// the load/store port. Data has fixed priority. A saturating streak counter makes
// sure fetch is eventually granted. Read data is registered, so every response
// arrives one cycle after its grant.
module mem_port_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              d_req,
    input  logic [DW/8-1:0]   d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic [AW-1:0]     mem_addr,
    output logic [DW/8-1:0]   mem_we,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_re,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int          BW         = DW / 8;
    localparam logic [3:0]  MAX_STREAK = 4'(MAX_DATA_STREAK);

    // Owner of the RAM in the previous cycle; this is also the port whose response
    // is presented in the current cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_IF,
        S_DATA
    } owner_t;

    owner_t          state_reg, state_next;
    logic [3:0]      streak_reg, streak_next;
    logic            d_read_reg;
    logic [DW-1:0]   if_rdata_reg;
    logic [DW-1:0]   d_rdata_reg;
    logic            starve;
    logic            d_is_read;

    assign d_is_read = (d_we == '0);

    // Grant decision. Data wins unless fetch has waited through a full streak.
    // Both grants are held low while reset is asserted.
    always_comb begin
        starve = if_req && (streak_reg == MAX_STREAK);
        d_gnt  = reset && d_req && !starve;
        if_gnt = reset && if_req && !(d_req && !starve);
    end

    // Drive the RAM from the port that owns it in this cycle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
            mem_re    = d_is_read;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_re    = 1'b1;
        end
    end

    // Streak counter: counts data grants while fetch waits, and saturates at the limit.
    always_comb begin
        streak_next = streak_reg;
        if (!if_req || if_gnt) begin
            streak_next = 4'd0;
        end else if (d_gnt && (streak_reg < MAX_STREAK)) begin
            streak_next = streak_reg + 4'd1;
        end
    end

    // Owner FSM next state: record which port is granted in this cycle.
    always_comb begin
        state_next = S_IDLE;
        if (if_gnt) begin
            state_next = S_IF;
        end else if (d_gnt) begin
            state_next = S_DATA;
        end
    end

    // State, streak and response registers. An async reset drops any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            streak_reg   <= 4'd0;
            d_read_reg   <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
            d_read_reg <= d_gnt && d_is_read;
            if (if_gnt) begin
                if_rdata_reg <= mem_rdata;
            end
            if (d_gnt && d_is_read) begin
                d_rdata_reg <= mem_rdata;
            end
        end
    end

    // Response outputs follow the previous cycle's owner. Stores never produce
    // a d_rvalid pulse.
    always_comb begin
        if_rvalid = (state_reg == S_IF);
        d_rvalid  = (state_reg == S_DATA) && d_read_reg;
        if_rdata  = if_rdata_reg;
        d_rdata   = d_rdata_reg;
    end

    // Only the low byte-enable width is meaningful; BW documents the strobe width.
    logic unused_ok;
    assign unused_ok = (BW == DW / 8);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A reference model predicts every grant
// from the arbitration rules and keeps its own copy of memory contents. Expected
// responses are queued, and an independent monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic [3:0]    d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic [31:0]   mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic          mem_re;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } resp_t;

    resp_t         if_q[$];
    resp_t         d_q[$];
    logic [31:0]   ram[64];
    logic [31:0]   ref_mem[64];
    int            m_streak = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Single-port RAM with combinational read and byte-enabled write
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predicts the grants from the arbitration rules and queues responses
    always @(negedge clk) begin
        logic eg_d, eg_if, starve;
        int   idx;
        if (!reset) begin
            m_streak = 0;
            if_q.delete();
            d_q.delete();
            chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
            chk("rst_mem", {27'd0, mem_re, mem_we}, 32'd0);
        end else begin
            starve = if_req && (m_streak == MAX);
            eg_d   = d_req && !starve;
            eg_if  = if_req && !eg_d;
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_if});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
            if (eg_if) begin
                idx = int'(if_addr[7:2]);
                chk("if_mem_addr", mem_addr, if_addr);
                chk("if_mem_ctl", {27'd0, mem_re, mem_we}, 32'h10);
                if_q.push_back('{cyc: cyc, data: ref_mem[idx]});
            end else if (eg_d) begin
                idx = int'(d_addr[7:2]);
                chk("d_mem_addr", mem_addr, d_addr);
                chk("d_mem_ctl", {27'd0, mem_re, mem_we}, {27'd0, d_we == 4'd0, d_we});
                if (d_we == 4'd0) begin
                    d_q.push_back('{cyc: cyc, data: ref_mem[idx]});
                end else begin
                    chk("d_mem_wdata", mem_wdata, d_wdata);
                    for (int b = 0; b < 4; b++)
                        if (d_we[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end else begin
                chk("idle_mem_ctl", {27'd0, mem_re, mem_we}, 32'd0);
            end
            if (!if_req || eg_if) m_streak = 0;
            else if (eg_d && m_streak < MAX) m_streak++;
        end
    end

    // Monitor: every response must arrive exactly one cycle after its grant
    always @(negedge clk) begin
        logic exp_if, exp_d;
        exp_if = reset && if_q.size() > 0 && if_q[0].cyc == cyc - 1;
        exp_d  = reset && d_q.size() > 0 && d_q[0].cyc == cyc - 1;
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, exp_if});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d});
        if (exp_if && if_rvalid) chk("if_rdata", if_rdata, if_q[0].data);
        if (exp_d && d_rvalid) chk("d_rdata", d_rdata, d_q[0].data);
        if (exp_if) void'(if_q.pop_front());
        if (exp_d) void'(d_q.pop_front());
    end

    task automatic wait_gnt(input bit is_if);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_if ? if_gnt : d_gnt;
        end
        chk("gnt_timeout", {31'd0, got}, 32'd1);
    endtask

    initial begin
        logic g_if, g_d, cont_ok;
        reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom; ref_mem[i] = ram[i];
        end
        ram[4] = 32'h00000013;     ref_mem[4] = ram[4];
        ram[8] = 32'h11223344;     ref_mem[8] = ram[8];
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        // Idle after reset: no strobes, no responses, cleared read data
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", {26'd0, if_gnt, d_gnt, mem_re, |mem_we, if_rvalid, d_rvalid}, 32'd0);
        end
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);

        // Fetch only
        @(posedge clk); #1 if_req = 1; if_addr = 32'h10;
        wait_gnt(1);
        chk("fetch_mem_re", {31'd0, mem_re}, 32'd1);
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h00000013);

        // Store then load back
        @(posedge clk); #1 d_req = 1; d_we = 4'b0011; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        wait_gnt(0);
        @(posedge clk); #1 d_req = 0; d_we = 0;
        @(negedge clk);
        chk("store_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        @(posedge clk); #1 d_req = 1; d_addr = 32'h20;
        wait_gnt(0);
        @(posedge clk); #1 d_req = 0;
        @(negedge clk);
        chk("load_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("load_rdata", d_rdata, 32'h1122BEEF);
        chk("rdata_hold_if", if_rdata, 32'h00000013);

        // Contention: both held high, grants repeat D,D,D,D,I
        @(posedge clk); #1 if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h44;
        cont_ok = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if ({if_gnt, d_gnt} != ((i % 5 == 4) ? 2'b10 : 2'b01)) cont_ok = 0;
        end
        chk("contention_pattern", {31'd0, cont_ok}, 32'd1);

        // Withdrawal: fetch waits 2 cycles under data saturation then drops;
        // the next fetch request must again wait a full streak
        @(posedge clk); #1 if_req = 0;
        @(posedge clk); #1 if_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        chk("withdraw_no_gnt", {31'd0, if_gnt}, 32'd0);
        @(posedge clk); #1 if_req = 1;
        cont_ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if_gnt != (i == 4)) cont_ok = 0;
        end
        chk("withdraw_streak_reset", {31'd0, cont_ok}, 32'd1);
        @(posedge clk); #1 if_req = 0; d_req = 0;

        // Reset during a pending read: the response must be dropped
        @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 32'h08;
        wait_gnt(0);
        #2 reset = 0; d_req = 0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        end
        #2 reset = 1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            g_if = if_gnt; g_d = d_gnt;
            @(posedge clk); #1;
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = {24'd0, 6'($urandom), 2'b00};
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 0;
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom);
                d_addr  = {24'd0, 6'($urandom), 2'b00};
                d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 0;
            end
        end
        @(posedge clk); #1 if_req = 0; d_req = 0;
        repeat (4) @(negedge clk);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-port, combinational-read data RAM between the instruction-fetch port and the load/store port of the core. It is the first step towards a unified-memory multi-cycle core.
- Fixed priority to data, with a starvation guard for fetch.
- Read data is registered, so each requester sees its response one cycle after its grant.
- At most one RAM access per cycle; grants can be back-to-back.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  if_rdata valid; one-cycle pulse.
- if_rdata  out  DW  fetch response.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  DW/8  byte write enables; 0 means read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  load data valid; pulses only for reads.
- d_rdata  out  DW  load response.
- mem_addr  out  AW  RAM address.
- mem_we  out  DW/8  RAM byte enables.
- mem_wdata  out  DW  RAM write data.
- mem_re  out  1  RAM read strobe.
- mem_rdata  in  DW  RAM combinational read data.

## Operation
- Owner FSM with states IDLE, IF, DATA records the grantee of the current cycle and is registered at the clock edge.
  - Next state is IF when if_gnt, DATA when d_gnt, otherwise IDLE.
- Grant rule, evaluated combinationally each cycle:
  - d_req and not starve → d_gnt.
  - Otherwise if_req → if_gnt.
  - Never both grants in the same cycle.
- starve = if_req && (streak == MAX_DATA_STREAK).
- streak is a 4-bit counter:
  - Increments on d_gnt while if_req is high.
  - Clears on if_gnt, or on any cycle with if_req low.
  - Saturates at MAX_DATA_STREAK.
- RAM drive in the grant cycle:
  - Fetch grant: mem_addr=if_addr, mem_we=0, mem_re=1.
  - Data grant: mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata, mem_re=(d_we==0).
  - No grant: mem_we=0, mem_re=0; mem_addr and mem_wdata are don't-care (implementation drives 0).
- Response: at the grant-cycle edge, mem_rdata is captured into the grantee's rdata register and the matching rvalid is set.
  - d_rvalid is set only for data reads.
  - Each rvalid clears the following cycle unless it is re-set by a new grant.
  - if_rdata and d_rdata hold their last value between responses.
- Arbiter does not check alignment; misalignment exceptions stay in the core.

## Timing
- Reset (reset=0), asynchronous:
  - FSM → IDLE, streak → 0.
  - if_rvalid, d_rvalid → 0; if_rdata, d_rdata → 0.
  - Grants and mem_we/mem_re are forced to 0 while reset is low.
- Reset asserted mid-transaction: a pending response is dropped, with no rvalid after release. A RAM write completes only if its grant cycle finished before reset fell.
- Latency: grant in cycle T, rvalid and data in T+1. Writes complete in T with no response.
- Throughput: one grant per cycle. Back-to-back grants to the same requester give consecutive rvalid pulses.
- Requests arriving in the same cycle: data wins unless starve.
- A requester must not change addr/we/wdata while req is high and gnt is low. Dropping req before gnt is legal; no grant results.

## Test plan
- Reset sequence: reset=0 then release, no requests → all outputs 0, FSM IDLE, no mem_re/mem_we for 10 cycles.
- Fetch only: if_req, if_addr=0x10, RAM word 0x00000013 → if_gnt in T, mem_re=1 in T; if_rvalid=1, if_rdata=0x00000013 in T+1.
- Store then load: d_we=4'b0011, d_addr=0x20, d_wdata=0xDEADBEEF over old 0x11223344 → no d_rvalid. Load of 0x20 → d_rdata=0x1122BEEF one cycle after grant.
- Contention, MAX_DATA_STREAK=4: if_req and d_req held high continuously → grant pattern D,D,D,D,I repeating; streak never exceeds 4.
- Reset mid-read: d_gnt in cycle T, reset falls before edge T+1 → d_rvalid stays 0; FSM IDLE after release.
- Request withdrawn: if_req raised while data is saturating, then dropped before grant → no if_gnt, streak returns to 0.
